// File: rtl/telem_pkg.sv
// -----------------------------------------------------------------------------
// telem_pkg
// Shared constants and types for the telemetry packet transmitter.
//   HDR0 / HDR1    : fixed packet header bytes (0xAA, 0x55)
//   CNT_W          : byte-counter width
//   MAX_NUM_BYTES  : largest supported payload length
//   state_e        : transmitter FSM states
// -----------------------------------------------------------------------------
package telem_pkg;

   localparam logic [7:0] HDR0 = 8'hAA;
   localparam logic [7:0] HDR1 = 8'h55;

   localparam int unsigned MAX_NUM_BYTES = 15;
   // Byte index reaches MAX_NUM_BYTES + 2 (two headers plus checksum), so 5 bits.
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT
   } state_e;

endpackage

// File: rtl/telem_chksum.sv
// -----------------------------------------------------------------------------
// telem_chksum
// 8-bit modulo-256 accumulator; output is the two's-complement negation of the
// running sum, so sum(payload) + chk == 0 mod 256.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   clr  : clear the accumulator (has priority over acc)
//   acc  : add din into the accumulator
//   din  : byte to accumulate
//   chk  : negated running sum
// -----------------------------------------------------------------------------
module telem_chksum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       acc,
   input  logic [7:0] din,
   output logic [7:0] chk
);

   logic [7:0] sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= 8'h00;
      end else if (clr) begin
         sum_q <= 8'h00;
      end else if (acc) begin
         sum_q <= sum_q + din;
      end
   end

   assign chk = ~sum_q + 8'd1;

endmodule

// File: rtl/telem_pkt_tx.sv
// -----------------------------------------------------------------------------
// telem_pkt_tx
// Frames a NUM_BYTES payload as 0xAA, 0x55, payload (MSB byte first) and, when
// TELEM_CHKSUM_EN is defined, a trailing checksum byte. Bytes are handed to a
// UART serializer over the trmt / tx_data / tx_done handshake.
// Build option:
//   TELEM_CHKSUM_EN : append negated modulo-256 payload sum as the last byte
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset
//   snd      : start a packet (sampled only in IDLE)
//   payload  : payload snapshot, byte NUM_BYTES-1 sent first
//   tx_done  : serializer byte-complete flag (rising edge = completion)
//   trmt     : one-cycle start pulse to the serializer
//   tx_data  : byte to the serializer, held from trmt until the next trmt
//   busy     : packet in progress
//   pkt_done : one-cycle pulse after the last byte completes
// -----------------------------------------------------------------------------
module telem_pkt_tx
   import telem_pkg::*;
#(
   parameter int unsigned NUM_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   snd,
   input  logic [8*NUM_BYTES-1:0] payload,
   input  logic                   tx_done,
   output logic                   trmt,
   output logic [7:0]             tx_data,
   output logic                   busy,
   output logic                   pkt_done
);

`ifdef TELEM_CHKSUM_EN
   localparam int unsigned LAST_K = NUM_BYTES + 2;
`else
   localparam int unsigned LAST_K = NUM_BYTES + 1;
`endif

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
   logic                   trmt_q, trmt_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   busy_q, busy_d;
   logic                   pkt_done_q, pkt_done_d;
   logic                   tx_done_q;

   logic       done_evt;
   logic       is_payload;
   logic [7:0] pay_byte;

   // Only a fresh rising edge counts; a level left high from an earlier byte does not.
   assign done_evt   = tx_done & ~tx_done_q;
   assign is_payload = (cnt_q >= CNT_W'(2)) && (cnt_q <= CNT_W'(NUM_BYTES + 1));

   // Byte index k = NUM_BYTES+1-i carries shadow byte i (MSB byte first).
   always_comb begin
      pay_byte = 8'h00;
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
         if (cnt_q == CNT_W'(NUM_BYTES + 1 - i)) begin
            pay_byte = shadow_q[8*i +: 8];
         end
      end
   end

`ifdef TELEM_CHKSUM_EN
   logic       chk_clr;
   logic       chk_acc;
   logic [7:0] chk_neg;

   telem_chksum u_chksum (
      .clk (clk),
      .rst (rst),
      .clr (chk_clr),
      .acc (chk_acc),
      .din (pay_byte),
      .chk (chk_neg)
   );
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      trmt_d     = 1'b0;
      tx_data_d  = tx_data_q;
      busy_d     = busy_q;
      pkt_done_d = 1'b0;
`ifdef TELEM_CHKSUM_EN
      chk_clr    = 1'b0;
      chk_acc    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            // A snd coinciding with pkt_done is dropped; IDLE honours it a cycle later.
            if (snd && !pkt_done_q) begin
               shadow_d = payload;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = SEND;
`ifdef TELEM_CHKSUM_EN
               chk_clr  = 1'b1;
`endif
            end
         end
         SEND: begin
            trmt_d  = 1'b1;
            state_d = WAIT;
            if (cnt_q == '0) begin
               tx_data_d = HDR0;
            end else if (cnt_q == CNT_W'(1)) begin
               tx_data_d = HDR1;
            end else if (is_payload) begin
               tx_data_d = pay_byte;
`ifdef TELEM_CHKSUM_EN
               chk_acc   = 1'b1;
            end else begin
               // All payload bytes were accumulated in earlier SEND cycles.
               tx_data_d = chk_neg;
`endif
            end
         end
         WAIT: begin
            if (done_evt) begin
               if (cnt_q == CNT_W'(LAST_K)) begin
                  pkt_done_d = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = IDLE;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shadow_q   <= '0;
         trmt_q     <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         pkt_done_q <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         trmt_q     <= trmt_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         pkt_done_q <= pkt_done_d;
         tx_done_q  <= tx_done;
      end
   end

   assign trmt     = trmt_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_telem_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_telem_pkt_tx
// Directed self-checking bench for telem_pkt_tx (NUM_BYTES = 4). Follows the
// TELEM_CHKSUM_EN setting of the build for the expected packet length.
// -----------------------------------------------------------------------------
module tb_telem_pkt_tx;

   localparam int NB = 4;
`ifdef TELEM_CHKSUM_EN
   localparam int LEN = NB + 3;
`else
   localparam int LEN = NB + 2;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            snd;
   logic [8*NB-1:0] payload;
   logic            tx_done;
   logic            trmt;
   logic [7:0]      tx_data;
   logic            busy;
   logic            pkt_done;

   int errors    = 0;
   int checks    = 0;
   int trmt_cnt  = 0;
   int pkt_cnt   = 0;
   logic [7:0] got [0:NB+2];

   telem_pkt_tx #(
      .NUM_BYTES (NB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .snd      (snd),
      .payload  (payload),
      .tx_done  (tx_done),
      .trmt     (trmt),
      .tx_data  (tx_data),
      .busy     (busy),
      .pkt_done (pkt_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (trmt === 1'b1) trmt_cnt++;
      if (pkt_done === 1'b1) pkt_cnt++;
   end

   function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pl);
      logic [7:0] s;
      s = 8'h00;
      if (k == 0) return 8'hAA;
      if (k == 1) return 8'h55;
      if (k < NB + 2) return pl[8*(NB+1-k) +: 8];
      for (int i = 0; i < NB; i++) s = s + pl[8*i +: 8];
      return 8'h00 - s;
   endfunction

   task automatic test_reset();
      rst = 1'b1; snd = 1'b0; tx_done = 1'b0; payload = '0;
      repeat (2) @(negedge clk);
      checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL reset_trmt got=%b exp=0", trmt); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got=%b exp=0", pkt_done); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         tx_done = 1'b1; repeat (3) @(negedge clk);
         tx_done = 1'b0; repeat (3) @(negedge clk);
      end
      checks++; if (trmt_cnt !== 0) begin errors++; $display("FAIL idle_trmt_count got=%0d exp=0", trmt_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
      checks++; if (pkt_cnt !== 0) begin errors++; $display("FAIL idle_pkt_done_count got=%0d exp=0", pkt_cnt); end
   endtask

   // Drives one packet through a serializer model that raises tx_done 20 cycles
   // after each trmt and drops it the cycle after the next trmt.
   task automatic run_packet(input logic [31:0] pl, input int inject_k, input logic [31:0] inj_pl,
                             input bit hold_first, input bit snd_at_done);
      int t0, p0;
      t0 = trmt_cnt; p0 = pkt_cnt;
      payload = pl; snd = 1'b1;
      @(negedge clk);
      snd = 1'b0; payload = ~pl;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_snd got=%b exp=1", busy); end
      checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL early_trmt got=%b exp=0", trmt); end
      @(negedge clk);
      checks++; if (trmt !== 1'b1) begin errors++; $display("FAIL first_trmt got=%b exp=1", trmt); end
      for (int k = 0; k < LEN; k++) begin
         got[k] = tx_data;
         checks++;
         if (tx_data !== exp_byte(k, pl)) begin
            errors++; $display("FAIL byte%0d got=%h exp=%h", k, tx_data, exp_byte(k, pl));
         end
         @(negedge clk);
         checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL trmt_width byte%0d got=%b exp=0", k, trmt); end
         if (hold_first && k == 0) begin
            // tx_done is still high from the previous packet: no advance allowed.
            repeat (10) @(negedge clk);
            checks++; if (trmt_cnt !== t0 + 1) begin errors++; $display("FAIL held_tx_done trmts got=%0d exp=%0d", trmt_cnt - t0, 1); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_tx_done busy got=%b exp=1", busy); end
         end
         tx_done = 1'b0;
         for (int j = 0; j < 19; j++) begin
            @(negedge clk);
            if (k == inject_k && j == 5) begin payload = inj_pl; snd = 1'b1; end
            else if (k == inject_k && j == 6) snd = 1'b0;
         end
         tx_done = 1'b1;
         @(negedge clk);
         if (k == LEN - 1) begin
            checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL pkt_done_latency got=%b exp=1", pkt_done); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got=%b exp=0", busy); end
            if (snd_at_done) snd = 1'b1;
            @(negedge clk);
            snd = 1'b0;
            checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL pkt_done_width got=%b exp=0", pkt_done); end
            if (snd_at_done) begin
               repeat (6) @(negedge clk);
               checks++; if (busy !== 1'b0) begin errors++; $display("FAIL snd_at_done busy got=%b exp=0", busy); end
               checks++; if (trmt_cnt !== t0 + LEN) begin errors++; $display("FAIL snd_at_done trmts got=%0d exp=%0d", trmt_cnt - t0, LEN); end
            end
         end else begin
            checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL trmt_early byte%0d got=%b exp=0", k + 1, trmt); end
            @(negedge clk);
            checks++; if (trmt !== 1'b1) begin errors++; $display("FAIL trmt_latency byte%0d got=%b exp=1", k + 1, trmt); end
         end
      end
      checks++; if (trmt_cnt !== t0 + LEN) begin errors++; $display("FAIL trmt_count got=%0d exp=%0d", trmt_cnt - t0, LEN); end
      checks++; if (pkt_cnt !== p0 + 1) begin errors++; $display("FAIL pkt_done_count got=%0d exp=1", pkt_cnt - p0); end
   endtask

   task automatic test_basic();
      logic [7:0] lit [0:6];
      logic [7:0] s;
      lit = '{8'hAA, 8'h55, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEC};
      run_packet(32'h12345678, -1, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < LEN; k++) begin
         checks++; if (got[k] !== lit[k]) begin errors++; $display("FAIL basic_seq byte%0d got=%h exp=%h", k, got[k], lit[k]); end
      end
`ifdef TELEM_CHKSUM_EN
      s = got[2] + got[3] + got[4] + got[5] + got[6];
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL chksum_sum got=%h exp=00", s); end
`else
      s = 8'h00;
`endif
   endtask

   task automatic test_tx_done_held();
      // tx_done is left high by the previous packet's model.
      checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL held_setup got=%b exp=1", tx_done); end
      run_packet(32'h00FF0180, -1, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_snd_while_busy();
      run_packet(32'hA1B2C3D4, 3, 32'hFFFFFFFF, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_packet(32'h0BADBEEF, -1, 32'h0, 1'b0, 1'b1);
      run_packet(32'hFEDCBA98, -1, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_rst_mid();
      int t0, p0;
      t0 = trmt_cnt; p0 = pkt_cnt;
      payload = 32'hCAFEF00D; snd = 1'b1;
      @(negedge clk);
      snd = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         tx_done = 1'b0;
         repeat (19) @(negedge clk);
         tx_done = 1'b1;
         repeat (2) @(negedge clk);
      end
      checks++; if (tx_data !== 8'hCA || trmt !== 1'b1) begin
         errors++; $display("FAIL rst_setup got=%h/%b exp=ca/1", tx_data, trmt);
      end
      @(negedge clk);
      tx_done = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL rst_trmt got=%b exp=0", trmt); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      tx_done = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (trmt_cnt !== t0 + 3) begin errors++; $display("FAIL rst_trmts got=%0d exp=3", trmt_cnt - t0); end
      checks++; if (pkt_cnt !== p0) begin errors++; $display("FAIL rst_pkt_done got=%0d exp=0", pkt_cnt - p0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
      run_packet(32'h01020304, -1, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tx_done_held();
      test_snd_while_busy();
      test_back_to_back();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
